// File: rtl/bp_me_wormhole_pkg.sv
// Shared types, processor-config constants and the wormhole header macro for
// the coherence-message-to-wormhole serializer.
package bp_me_wormhole_pkg;

  typedef enum logic [1:0] {e_bp_default_cfg} bp_params_e;

  localparam int cce_id_width_p         = 3;
  localparam int coh_noc_x_cord_width_p = 4;
  localparam int coh_noc_y_cord_width_p = 4;
  localparam int coh_noc_cord_width_p   = coh_noc_x_cord_width_p + coh_noc_y_cord_width_p;
  localparam int coh_noc_cid_width_p    = 2;
  localparam int coh_noc_len_width_p    = 4;

  // Tile geometry: core complex starts at (sac_x_dim_p, ic_y_dim_p); the
  // memory-complex CCEs sit in the row just below it.
  localparam int num_core_p  = 4;
  localparam int cc_x_dim_p  = 2;
  localparam int cc_y_dim_p  = 2;
  localparam int sac_x_dim_p = 1;
  localparam int ic_y_dim_p  = 1;

  typedef enum logic [1:0] {e_ready, e_hdr, e_data} wh_state_e;

  function automatic int flit_count(input int bits, input int flit_width);
    return (bits + flit_width - 1) / flit_width;
  endfunction

endpackage

// Packed so that cord lands in the LSBs, followed by len, cid and msg_hdr.
`define DECLARE_BP_ME_WORMHOLE_HEADER_S(cord_w, len_w, cid_w, hdr_w) \
  typedef struct packed {                                          \
    logic [hdr_w-1:0]  msg_hdr;                                    \
    logic [cid_w-1:0]  cid;                                        \
    logic [len_w-1:0]  len;                                        \
    logic [cord_w-1:0] cord;                                       \
  } bp_me_wormhole_header_s

// File: rtl/bp_me_cce_id_to_cord.sv
// Maps a CCE ID to its NoC coordinate and cid; core-complex IDs fill the
// CC grid row-major, memory-complex IDs occupy the row below it.
module bp_me_cce_id_to_cord
  import bp_me_wormhole_pkg::*;
  (
    input  logic [cce_id_width_p-1:0]       cce_id_i,
    output logic [coh_noc_cord_width_p-1:0] cord_o,
    output logic [coh_noc_cid_width_p-1:0]  cid_o
  );

  logic [coh_noc_x_cord_width_p-1:0] x_cord;
  logic [coh_noc_y_cord_width_p-1:0] y_cord;

  always_comb begin
    x_cord = '0;
    y_cord = '0;
    if (int'(cce_id_i) < num_core_p) begin
      x_cord = coh_noc_x_cord_width_p'(sac_x_dim_p + int'(cce_id_i) % cc_x_dim_p);
      y_cord = coh_noc_y_cord_width_p'(ic_y_dim_p + int'(cce_id_i) / cc_x_dim_p);
    end else begin
      x_cord = coh_noc_x_cord_width_p'(sac_x_dim_p + int'(cce_id_i) - num_core_p);
      y_cord = coh_noc_y_cord_width_p'(ic_y_dim_p + cc_y_dim_p);
    end
  end

  assign cord_o = {y_cord, x_cord};
  assign cid_o  = '0;

endmodule

// File: rtl/bp_me_cce_msg_to_wormhole.sv
// Serializes one coherence message (wormhole header + up to a line of data)
// into flits on the coherence NoC link.
module bp_me_cce_msg_to_wormhole
  import bp_me_wormhole_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   , parameter int flit_width_p     = 64
   , parameter int msg_hdr_width_p  = 96
   , parameter int msg_data_width_p = 512
   , localparam int hdr_bits_lp = coh_noc_cord_width_p + coh_noc_len_width_p
                                + coh_noc_cid_width_p + msg_hdr_width_p
   , localparam int hdr_flits_lp        = flit_count(hdr_bits_lp, flit_width_p)
   , localparam int max_data_flits_lp   = flit_count(msg_data_width_p, flit_width_p)
   , localparam int data_flits_width_lp = $clog2(max_data_flits_lp + 1)
   )
  (
    input  logic                           clk_i,
    input  logic                           reset_i,
    // Both sides are valid-ready-and: a transfer happens on a rising edge
    // where valid and ready are both 1; valid never waits on ready.
    input  logic                           msg_v_i,
    output logic                           msg_ready_and_o,
    input  logic [cce_id_width_p-1:0]      msg_dst_id_i,
    input  logic [msg_hdr_width_p-1:0]     msg_hdr_i,
    input  logic [msg_data_width_p-1:0]    msg_data_i,
    input  logic [data_flits_width_lp-1:0] msg_data_flits_i,
    output logic                           link_v_o,
    output logic [flit_width_p-1:0]        link_data_o,
    input  logic                           link_ready_and_i
  );

  localparam int hdr_idx_w_lp  = (hdr_flits_lp > 1) ? $clog2(hdr_flits_lp) : 1;
  localparam int data_idx_w_lp = (max_data_flits_lp > 1) ? $clog2(max_data_flits_lp) : 1;
  localparam int cnt_w_lp      = data_flits_width_lp;

  if (hdr_flits_lp + max_data_flits_lp - 1 >= (1 << coh_noc_len_width_p)) begin : g_len_chk
    $error("wormhole len field too narrow for the largest packet");
  end
  if (hdr_idx_w_lp > cnt_w_lp || hdr_flits_lp > (1 << cnt_w_lp)) begin : g_cnt_chk
    $error("flit counter too narrow for the header flits");
  end
  if (bp_params_p != e_bp_default_cfg) begin : g_cfg_chk
    $error("unsupported processor configuration");
  end

  `DECLARE_BP_ME_WORMHOLE_HEADER_S(coh_noc_cord_width_p, coh_noc_len_width_p,
                                   coh_noc_cid_width_p, msg_hdr_width_p);

  wh_state_e                      state_r, state_n;
  logic [cnt_w_lp-1:0]            cnt_r, cnt_n;
  logic [cce_id_width_p-1:0]      dst_id_r;
  logic [msg_hdr_width_p-1:0]     msg_hdr_r;
  logic [msg_data_width_p-1:0]    msg_data_r;
  logic [data_flits_width_lp-1:0] data_flits_r, data_flits_sat;
  logic                           accept, last_hdr, last_data;

  logic [coh_noc_cord_width_p-1:0]             dst_cord;
  logic [coh_noc_cid_width_p-1:0]              dst_cid;
  bp_me_wormhole_header_s                      hdr_s;
  logic [hdr_flits_lp-1:0][flit_width_p-1:0]      hdr_flits;
  logic [max_data_flits_lp-1:0][flit_width_p-1:0] data_words;

  bp_me_cce_id_to_cord u_id_to_cord (
    .cce_id_i (dst_id_r),
    .cord_o   (dst_cord),
    .cid_o    (dst_cid)
  );

  assign data_flits_sat = (msg_data_flits_i > data_flits_width_lp'(max_data_flits_lp))
                        ? data_flits_width_lp'(max_data_flits_lp) : msg_data_flits_i;

  assign hdr_s.cord    = dst_cord;
  assign hdr_s.len     = coh_noc_len_width_p'(hdr_flits_lp + int'(data_flits_r) - 1);
  assign hdr_s.cid     = dst_cid;
  assign hdr_s.msg_hdr = msg_hdr_r;

  assign hdr_flits  = (hdr_flits_lp * flit_width_p)'(hdr_s);
  assign data_words = (max_data_flits_lp * flit_width_p)'(msg_data_r);

  assign msg_ready_and_o = (state_r == e_ready);
  assign accept          = msg_v_i & msg_ready_and_o;
  assign last_hdr        = (cnt_r == cnt_w_lp'(hdr_flits_lp - 1));
  assign last_data       = (cnt_r == data_flits_r - data_flits_width_lp'(1));

  // Outputs depend only on registered state, never on link_ready_and_i.
  assign link_v_o    = (state_r != e_ready);
  assign link_data_o = (state_r == e_data) ? data_words[cnt_r[data_idx_w_lp-1:0]]
                                           : hdr_flits[cnt_r[hdr_idx_w_lp-1:0]];

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      e_ready: if (accept) begin
        state_n = e_hdr;
        cnt_n   = '0;
      end
      e_hdr: if (link_ready_and_i) begin
        if (last_hdr) begin
          state_n = (data_flits_r == '0) ? e_ready : e_data;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      e_data: if (link_ready_and_i) begin
        if (last_data) begin
          state_n = e_ready;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      default: begin
        state_n = e_ready;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      dst_id_r     <= msg_dst_id_i;
      msg_hdr_r    <= msg_hdr_i;
      msg_data_r   <= msg_data_i;
      data_flits_r <= data_flits_sat;
    end
    if (!reset_i && accept)
      assert (msg_data_flits_i <= data_flits_width_lp'(max_data_flits_lp))
        else $warning("msg_data_flits_i above maximum, saturated");
  end

endmodule

// File: tb/tb_bp_me_cce_msg_to_wormhole.sv
// Directed bench for the coherence-message-to-wormhole serializer: a flit
// scoreboard plus cycle-exact checks of accept, stall and reset timing.
module tb_bp_me_cce_msg_to_wormhole;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         msg_v_i;
  logic         msg_ready_and_o;
  logic [2:0]   msg_dst_id_i;
  logic [95:0]  msg_hdr_i;
  logic [511:0] msg_data_i;
  logic [3:0]   msg_data_flits_i;
  logic         link_v_o;
  logic [63:0]  link_data_o;
  logic         link_ready_and_i;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bp_me_cce_msg_to_wormhole dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .msg_v_i          (msg_v_i),
    .msg_ready_and_o  (msg_ready_and_o),
    .msg_dst_id_i     (msg_dst_id_i),
    .msg_hdr_i        (msg_hdr_i),
    .msg_data_i       (msg_data_i),
    .msg_data_flits_i (msg_data_flits_i),
    .link_v_o         (link_v_o),
    .link_data_o      (link_data_o),
    .link_ready_and_i (link_ready_and_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [511:0] mk_data(input logic [31:0] seed);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = {seed, 32'(k)};
    return d;
  endfunction

  // Expected flits: header {msg_hdr, cid=0, len, cord} LSB first, then data.
  task automatic push_exp(input logic [7:0] cord, input logic [95:0] hdr,
                          input logic [511:0] data, input int n);
    int         ns;
    logic [3:0] len;
    ns  = (n > 8) ? 8 : n;
    len = 4'(1 + ns);
    exp_q.push_back({hdr[49:0], 2'b00, len, cord});
    exp_q.push_back({18'b0, hdr[95:50]});
    for (int k = 0; k < ns; k++) exp_q.push_back(data[k*64 +: 64]);
  endtask

  task automatic send(input logic [2:0] dst, input logic [95:0] hdr, input logic [511:0] data,
                      input logic [3:0] n, input logic [7:0] cord);
    int waited;
    waited = 0;
    push_exp(cord, hdr, data, int'(n));
    msg_v_i          = 1'b1;
    msg_dst_id_i     = dst;
    msg_hdr_i        = hdr;
    msg_data_i       = data;
    msg_data_flits_i = n;
    @(negedge clk);
    while (!msg_ready_and_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 64'(msg_ready_and_o), 64'd1);
    @(posedge clk); #1;
    msg_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || !msg_ready_and_o) && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset_i && link_v_o && link_ready_and_i) begin
      if (exp_q.size() == 0) check("q_size_at_flit", 64'(exp_q.size()), 64'd1);
      else check("flit", link_data_o, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0]  hdr_a;
    logic [511:0] dat_a;
    logic [63:0]  held;
    reset_i = 1'b1; msg_v_i = 1'b0; msg_dst_id_i = '0; msg_hdr_i = '0;
    msg_data_i = '0; msg_data_flits_i = '0; link_ready_and_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    step();
    check("rst_ready", 64'(msg_ready_and_o), 64'd1);
    check("rst_v", 64'(link_v_o), 64'd0);

    // Full line to core-complex CCE 0: cord (1,1), len 9.
    send(3'd0, 96'h0123_4567_89AB_CDEF_FEDC_BA98, mk_data(32'hC0DE_0001), 4'd8, 8'h11);
    check("t1_first_v", 64'(link_v_o), 64'd1);
    check("t1_ready_low", 64'(msg_ready_and_o), 64'd0);
    check("t1_cord", 64'(link_data_o[7:0]), 64'h11);
    check("t1_len", 64'(link_data_o[11:8]), 64'd9);
    wait_idle();

    // Header-only message, then an immediate accept in the freed cycle.
    send(3'd0, 96'hA5, '0, 4'd0, 8'h11);
    check("t2_flit0", link_data_o, 64'h0000_0000_0029_4111);
    step();
    check("t2_flit1", link_data_o, 64'h0);
    check("t2_v_flit1", 64'(link_v_o), 64'd1);
    step();
    check("t2_ready_after", 64'(msg_ready_and_o), 64'd1);
    check("t2_v_after", 64'(link_v_o), 64'd0);
    send(3'd2, 96'h1, mk_data(32'h0000_0002), 4'd1, 8'h21);
    check("t2_next_v", 64'(link_v_o), 64'd1);
    wait_idle();

    // Stall on data flit 3 for two extra cycles.
    send(3'd3, 96'hBEEF_0003, mk_data(32'h5741_1003), 4'd8, 8'h22);
    repeat (5) step();
    check("t3_dflit3", link_data_o, {32'h5741_1003, 32'h3});
    held = link_data_o;
    link_ready_and_i = 1'b0;
    step();
    check("t3_hold1", link_data_o, held);
    check("t3_hold1_v", 64'(link_v_o), 64'd1);
    step();
    check("t3_hold2", link_data_o, held);
    link_ready_and_i = 1'b1;
    wait_idle();

    // Oversized data count saturates to 8 flits, len 9.
    send(3'd0, 96'h9999, mk_data(32'h0000_0009), 4'd9, 8'h11);
    check("t4_len", 64'(link_data_o[11:8]), 64'd9);
    wait_idle();

    // Reset after flit 4 of 10 abandons the packet.
    send(3'd0, 96'h5555, mk_data(32'h0000_0005), 4'd8, 8'h11);
    repeat (5) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("t5_v_after_rst", 64'(link_v_o), 64'd0);
    check("t5_ready_after_rst", 64'(msg_ready_and_o), 64'd1);
    exp_q.delete();
    hdr_a = 96'hFACE_CAFE_0000_1234_5678;
    send(3'd4, hdr_a, mk_data(32'h0000_0006), 4'd2, 8'h31);
    check("t5_hdr0", link_data_o, {hdr_a[49:0], 2'b00, 4'd3, 8'h31});
    wait_idle();

    // Back-to-back to memory-complex CCEs with msg_v_i held high.
    dat_a = mk_data(32'h0000_00AA);
    push_exp(8'h31, 96'hAAAA, dat_a, 8);
    push_exp(8'h32, 96'hBBBB, mk_data(32'h0000_00BB), 2);
    check("t6_ready_start", 64'(msg_ready_and_o), 64'd1);
    msg_v_i = 1'b1; msg_dst_id_i = 3'd4; msg_hdr_i = 96'hAAAA;
    msg_data_i = dat_a; msg_data_flits_i = 4'd8;
    step();
    msg_dst_id_i = 3'd5; msg_hdr_i = 96'hBBBB;
    msg_data_i = mk_data(32'h0000_00BB); msg_data_flits_i = 4'd2;
    for (int i = 0; i < 10; i++) begin
      check("t6_ready_low", 64'(msg_ready_and_o), 64'd0);
      step();
    end
    check("t6_ready_free", 64'(msg_ready_and_o), 64'd1);
    step();
    msg_v_i = 1'b0;
    check("t6_b_v", 64'(link_v_o), 64'd1);
    check("t6_b_cord", 64'(link_data_o[7:0]), 64'h32);
    check("t6_b_y", 64'(link_data_o[7:4]), 64'd3);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
